qubit_gate_engine: RTL and testbench
====================================

# qubit_gate_engine

Two-qubit state-vector gate engine. It holds the four complex amplitudes of a 2-qubit register in signed Q1.15 (1.0 = 32767) and applies one gate per valid/ready handshake. Its amplitude outputs drive the amplitude inputs of the measurement sampler directly downstream. A single shared multiplier is used for Hadamard; every other gate is a one-cycle permutation or sign operation.

## Interface
- No parameters. The constant K = 23170 (1/sqrt2 in Q0.15) is fixed.
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high; forces the register to |00> and the FSM to IDLE.
- init  in  1  synchronous re-initialise to |00>; honoured only in IDLE.
- gate_valid  in  1  a gate request is present.
- gate_ready  out  1  high when the block can accept a gate: `(state == IDLE) && !init`.
- gate_op  in  3  0 NOP, 1 X, 2 Z, 3 H, 4 S, 5 CNOT, 6 SWAP, 7 NOP.
- gate_target  in  1  target qubit: 0 = index bit0 (LSB), 1 = index bit1.
- amp00_real, amp00_imag … amp11_real, amp11_imag  out  16 each, signed  current state vector, registered.
- gate_count  out  8  number of gates committed since reset/init; wraps 255→0.

## Operation
- Reset values: amp00_real = 32767, all other amplitudes 0, gate_count = 0, gate_ready = 1.
- FSM states: IDLE, APPLY, HMUL.
  - In IDLE, if init: load |00>, clear gate_count, stay in IDLE.
  - In IDLE, on handshake (gate_valid && gate_ready): latch op and target. If op = H go to HMUL with step = 0; otherwise go to APPLY.
  - In APPLY: commit the gate, then return to IDLE.
  - In HMUL: step counts 0..7; at step 7, commit and return to IDLE.
- Pairs for target 0: (00,01), (10,11). Pairs for target 1: (00,10), (01,11). Call the first member of a pair a (target bit = 0) and the second b (target bit = 1).
- X: swap a and b in each pair.
- Z: b ← −b.
- S: b ← i·b, i.e. (re, im) → (−im, re).
- CNOT: the control is the other qubit. Swap the amplitudes whose control bit is 1: target 0 swaps 10↔11; target 1 swaps 01↔11.
- SWAP: swap 01↔10. gate_target is ignored.
- NOP (op 0 and op 7): no amplitude change, but still counted.
- Negation saturates: −(−32768) = 32767.
- H: for each pair and each component (real, imag):
  - a' = ((a+b)·K) >>> 15
  - b' = ((a−b)·K) >>> 15
  - This gives 8 products, one per HMUL cycle, computed on a single signed 17×16 multiplier.
  - The shift is arithmetic, i.e. truncation toward −inf.
  - Each result saturates to [−32768, 32767].
  - Products are held in scratch registers. All 8 amplitudes are written back together, so outputs never show a partially updated state.
- gate_count increments by 1 at every commit, for all ops.
- gate_valid, gate_op and gate_target are ignored outside IDLE. init is ignored outside IDLE.

## Timing
- Handshake at edge N:
  - Non-H gate: amplitudes update at edge N+1. gate_ready is high again after edge N+1.
  - H: amplitudes update at edge N+8. gate_ready is low for 8 cycles and high after edge N+8.
- Back-to-back non-H gates are accepted every 2 cycles.
- init and gate_valid high in the same IDLE cycle: init wins, gate_ready = 0, and no gate is accepted.
- Reset asserted mid-HMUL: scratch registers are discarded, the state goes to |00> immediately, and gate_count = 0.
- Amplitude outputs stay stable between commits, so the downstream sampler may sample them on any cycle.

## Test plan
- Reset, then H on target 0 → after 8 cycles amp00_real = amp01_real = 23169, all others 0, gate_count = 1; gate_ready low for exactly 8 cycles.
- Continue from the previous state with CNOT on target 1 → next cycle amp00_real = 23169, amp11_real = 23169, amp01 = amp10 = 0 (Bell state).
- From |00>, H on target 0 twice → amp00_real = 32765, amp01_real = 0.
- From |00>: X on target 0 → amp01_real = 32767; then S on target 0 → amp01 = (0, 32767); then Z on target 0 → amp01 = (0, −32767); then SWAP → amp10 = (0, −32767).
- Assert init together with gate_valid (op X) in IDLE → gate_ready = 0, state |00>, gate_count = 0, and the gate is not applied.
- Assert reset at the 4th HMUL cycle → immediately amp00_real = 32767, all others 0, gate_ready = 1 once reset is released, and no write-back occurs.
- Issue 256 NOPs → gate_count wraps to 0 and the amplitudes are unchanged.

Source files
------------

// File: rtl/qubit_gate_engine.sv
// Two-qubit state-vector gate engine: four Q1.15 complex amplitudes, one gate per handshake.
// Hadamard runs as eight products on one shared 17x16 multiplier; all other gates commit in one cycle.
module qubit_gate_engine (
    input  logic               clk,
    input  logic               reset,
    input  logic               init,
    input  logic               gate_valid,
    output logic               gate_ready,
    input  logic [2:0]         gate_op,
    input  logic               gate_target,
    output logic signed [15:0] amp00_real,
    output logic signed [15:0] amp00_imag,
    output logic signed [15:0] amp01_real,
    output logic signed [15:0] amp01_imag,
    output logic signed [15:0] amp10_real,
    output logic signed [15:0] amp10_imag,
    output logic signed [15:0] amp11_real,
    output logic signed [15:0] amp11_imag,
    output logic [7:0]         gate_count
);

    localparam logic signed [15:0] K       = 16'sd23170;
    localparam logic [2:0]         OP_X    = 3'd1;
    localparam logic [2:0]         OP_Z    = 3'd2;
    localparam logic [2:0]         OP_H    = 3'd3;
    localparam logic [2:0]         OP_S    = 3'd4;
    localparam logic [2:0]         OP_CNOT = 3'd5;
    localparam logic [2:0]         OP_SWAP = 3'd6;

    typedef enum logic [1:0] {IDLE, APPLY, HMUL} state_t;

    state_t state;
    state_t state_next;

    logic [2:0]         op_q;
    logic               tgt_q;
    logic [2:0]         step;

    // Amplitude arrays are indexed by the basis state {bit1, bit0}.
    logic signed [15:0] re [4];
    logic signed [15:0] im [4];
    logic signed [15:0] scr_re [4];
    logic signed [15:0] scr_im [4];
    logic signed [15:0] app_re [4];
    logic signed [15:0] app_im [4];
    logic signed [15:0] hn_re [4];
    logic signed [15:0] hn_im [4];

    logic [1:0]         tmask;
    logic [1:0]         cmask;
    logic [1:0]         ia;
    logic [1:0]         ib;
    logic [1:0]         hdst;
    logic signed [15:0] opa;
    logic signed [15:0] opb;
    logic signed [16:0] mop;
    logic signed [32:0] prod;
    logic signed [15:0] hres;

    function automatic logic signed [15:0] neg_sat(input logic signed [15:0] v);
        if (v == -16'sd32768) return 16'sd32767;
        return -v;
    endfunction

    function automatic logic signed [15:0] hsat(input logic signed [32:0] p);
        logic signed [32:0] s;
        s = p >>> 15;
        if (s > 33'sd32767)  return 16'sd32767;
        if (s < -33'sd32768) return -16'sd32768;
        return s[15:0];
    endfunction

    // Handshake: a gate is taken on a rising edge where gate_valid && gate_ready; ready only in IDLE without init.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (!init && gate_valid)
                    state_next = (gate_op == OP_H) ? HMUL : APPLY;
            end
            APPLY:   state_next = IDLE;
            HMUL:    if (step == 3'd7) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        gate_ready = (state == IDLE) && !init;
    end

    assign tmask = tgt_q ? 2'b10 : 2'b01;
    assign cmask = tgt_q ? 2'b01 : 2'b10;

    // Step bits: [2] pair, [1] component (0 real, 1 imag), [0] a' (sum) or b' (difference).
    always_comb begin
        ia   = tgt_q ? {1'b0, step[2]} : {step[2], 1'b0};
        ib   = ia | tmask;
        hdst = step[0] ? ib : ia;
        opa  = step[1] ? im[ia] : re[ia];
        opb  = step[1] ? im[ib] : re[ib];
        mop  = step[0] ? (17'(opa) - 17'(opb)) : (17'(opa) + 17'(opb));
        prod = 33'(mop) * 33'(K);
        hres = hsat(prod);
    end

    // Scratch image with this cycle's product merged in; becomes the state at step 7.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            hn_re[i] = scr_re[i];
            hn_im[i] = scr_im[i];
        end
        if (step[1]) hn_im[hdst] = hres;
        else         hn_re[hdst] = hres;
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            app_re[i] = re[i];
            app_im[i] = im[i];
        end
        case (op_q)
            OP_X: begin
                for (int i = 0; i < 4; i++) begin
                    app_re[i] = re[2'(i) ^ tmask];
                    app_im[i] = im[2'(i) ^ tmask];
                end
            end
            OP_Z: begin
                for (int i = 0; i < 4; i++) begin
                    if ((2'(i) & tmask) != 2'b00) begin
                        app_re[i] = neg_sat(re[i]);
                        app_im[i] = neg_sat(im[i]);
                    end
                end
            end
            OP_S: begin
                for (int i = 0; i < 4; i++) begin
                    if ((2'(i) & tmask) != 2'b00) begin
                        app_re[i] = neg_sat(im[i]);
                        app_im[i] = re[i];
                    end
                end
            end
            OP_CNOT: begin
                for (int i = 0; i < 4; i++) begin
                    if ((2'(i) & cmask) != 2'b00) begin
                        app_re[i] = re[2'(i) ^ tmask];
                        app_im[i] = im[2'(i) ^ tmask];
                    end
                end
            end
            OP_SWAP: begin
                app_re[1] = re[2];
                app_im[1] = im[2];
                app_re[2] = re[1];
                app_im[2] = im[1];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            re         <= '{16'sd32767, 16'sd0, 16'sd0, 16'sd0};
            im         <= '{16'sd0, 16'sd0, 16'sd0, 16'sd0};
            scr_re     <= '{16'sd0, 16'sd0, 16'sd0, 16'sd0};
            scr_im     <= '{16'sd0, 16'sd0, 16'sd0, 16'sd0};
            op_q       <= 3'd0;
            tgt_q      <= 1'b0;
            step       <= 3'd0;
            gate_count <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (init) begin
                        re         <= '{16'sd32767, 16'sd0, 16'sd0, 16'sd0};
                        im         <= '{16'sd0, 16'sd0, 16'sd0, 16'sd0};
                        gate_count <= 8'd0;
                    end else if (gate_valid) begin
                        op_q  <= gate_op;
                        tgt_q <= gate_target;
                        step  <= 3'd0;
                    end
                end
                APPLY: begin
                    re         <= app_re;
                    im         <= app_im;
                    gate_count <= gate_count + 8'd1;
                end
                HMUL: begin
                    scr_re <= hn_re;
                    scr_im <= hn_im;
                    step   <= step + 3'd1;
                    if (step == 3'd7) begin
                        re         <= hn_re;
                        im         <= hn_im;
                        gate_count <= gate_count + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign amp00_real = re[0];
    assign amp00_imag = im[0];
    assign amp01_real = re[1];
    assign amp01_imag = im[1];
    assign amp10_real = re[2];
    assign amp10_imag = im[2];
    assign amp11_real = re[3];
    assign amp11_imag = im[3];

endmodule

// File: tb/tb_qubit_gate_engine.sv
// Bench for qubit_gate_engine: directed scenarios with literal expectations plus randomized traffic,
// all compared every cycle against a gate-level arithmetic model of the state vector.
module tb_qubit_gate_engine;

    logic               clk = 1'b0;
    logic               reset;
    logic               init;
    logic               gate_valid;
    logic               gate_ready;
    logic [2:0]         gate_op;
    logic               gate_target;
    logic signed [15:0] amp00_real, amp00_imag, amp01_real, amp01_imag;
    logic signed [15:0] amp10_real, amp10_imag, amp11_real, amp11_imag;
    logic [7:0]         gate_count;

    always #5 clk = ~clk;

    qubit_gate_engine dut (
        .clk         (clk),
        .reset       (reset),
        .init        (init),
        .gate_valid  (gate_valid),
        .gate_ready  (gate_ready),
        .gate_op     (gate_op),
        .gate_target (gate_target),
        .amp00_real  (amp00_real),
        .amp00_imag  (amp00_imag),
        .amp01_real  (amp01_real),
        .amp01_imag  (amp01_imag),
        .amp10_real  (amp10_real),
        .amp10_imag  (amp10_imag),
        .amp11_real  (amp11_real),
        .amp11_imag  (amp11_imag),
        .gate_count  (gate_count)
    );

    logic signed [15:0] d_re [4];
    logic signed [15:0] d_im [4];
    assign d_re[0] = amp00_real;
    assign d_im[0] = amp00_imag;
    assign d_re[1] = amp01_real;
    assign d_im[1] = amp01_imag;
    assign d_re[2] = amp10_real;
    assign d_im[2] = amp10_imag;
    assign d_re[3] = amp11_real;
    assign d_im[3] = amp11_imag;

    int m_re [4];
    int m_im [4];
    int m_cnt;
    int m_busy;
    int p_op;
    int p_tgt;
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s actual %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sat(input int v);
        if (v > 32767)  return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    task automatic model_reset();
        m_re   = '{32767, 0, 0, 0};
        m_im   = '{0, 0, 0, 0};
        m_cnt  = 0;
        m_busy = 0;
    endtask

    task automatic model_apply(input int op, input int t);
        int o_re [4];
        int o_im [4];
        int m;
        int c;
        o_re = m_re;
        o_im = m_im;
        m = (t != 0) ? 2 : 1;
        c = (t != 0) ? 1 : 2;
        for (int i = 0; i < 4; i++) begin
            case (op)
                1: begin
                    m_re[i] = o_re[i ^ m];
                    m_im[i] = o_im[i ^ m];
                end
                2: if ((i & m) != 0) begin
                    m_re[i] = sat(-o_re[i]);
                    m_im[i] = sat(-o_im[i]);
                end
                3: begin
                    if ((i & m) == 0) begin
                        m_re[i]     = sat(((o_re[i] + o_re[i | m]) * 23170) >>> 15);
                        m_im[i]     = sat(((o_im[i] + o_im[i | m]) * 23170) >>> 15);
                        m_re[i | m] = sat(((o_re[i] - o_re[i | m]) * 23170) >>> 15);
                        m_im[i | m] = sat(((o_im[i] - o_im[i | m]) * 23170) >>> 15);
                    end
                end
                4: if ((i & m) != 0) begin
                    m_re[i] = sat(-o_im[i]);
                    m_im[i] = o_re[i];
                end
                5: if ((i & c) != 0) begin
                    m_re[i] = o_re[i ^ m];
                    m_im[i] = o_im[i ^ m];
                end
                6: if (i == 1 || i == 2) begin
                    m_re[i] = o_re[3 - i];
                    m_im[i] = o_im[3 - i];
                end
                default: ;
            endcase
        end
    endtask

    // Model: a gate accepted at an edge commits 1 (non-H) or 8 (H) edges later.
    task automatic model_loop();
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                model_reset();
            end else if (m_busy > 0) begin
                m_busy--;
                if (m_busy == 0) begin
                    model_apply(p_op, p_tgt);
                    m_cnt = (m_cnt + 1) % 256;
                end
            end else if (init) begin
                model_reset();
            end else if (gate_valid) begin
                p_op   = int'(gate_op);
                p_tgt  = int'(gate_target);
                m_busy = (gate_op == 3'd3) ? 8 : 1;
            end
        end
    endtask

    task automatic compare_loop();
        forever begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                check($sformatf("amp%0d_re", i), int'(d_re[i]), m_re[i]);
                check($sformatf("amp%0d_im", i), int'(d_im[i]), m_im[i]);
            end
            check("gate_count", int'(gate_count), m_cnt);
            check("gate_ready", int'(gate_ready), int'(m_busy == 0 && !init));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic issue(input int op, input int t, output int low);
        int n;
        n = 0;
        while (!gate_ready && n < 50) begin
            tick();
            n++;
        end
        if (!gate_ready) check("issue_ready_timeout", 0, 1);
        gate_valid  = 1'b1;
        gate_op     = 3'(op);
        gate_target = 1'(t);
        tick();
        gate_valid = 1'b0;
        low = 0;
        while (!gate_ready && low < 50) begin
            tick();
            low++;
        end
    endtask

    initial begin
        int low;
        reset       = 1'b1;
        init        = 1'b0;
        gate_valid  = 1'b0;
        gate_op     = 3'd0;
        gate_target = 1'b0;
        model_reset();
        fork
            model_loop();
            compare_loop();
        join_none
        tick();
        tick();
        reset = 1'b0;
        #1;
        check("rst_amp00_re", int'(amp00_real), 32767);
        check("rst_count", int'(gate_count), 0);
        check("rst_ready", int'(gate_ready), 1);

        // Hadamard on qubit 0, then CNOT targeting qubit 1: Bell state.
        issue(3, 0, low);
        check("h_ready_low", low, 8);
        check("h_amp00_re", int'(amp00_real), 23169);
        check("h_amp01_re", int'(amp01_real), 23169);
        check("h_amp10_re", int'(amp10_real), 0);
        check("h_amp00_im", int'(amp00_imag), 0);
        check("h_count", int'(gate_count), 1);
        issue(5, 1, low);
        check("cnot_ready_low", low, 1);
        check("bell_amp00_re", int'(amp00_real), 23169);
        check("bell_amp11_re", int'(amp11_real), 23169);
        check("bell_amp01_re", int'(amp01_real), 0);
        check("bell_amp10_re", int'(amp10_real), 0);

        do_reset();
        issue(3, 0, low);
        issue(3, 0, low);
        check("hh_amp00_re", int'(amp00_real), 32765);
        check("hh_amp01_re", int'(amp01_real), 0);

        do_reset();
        issue(1, 0, low);
        check("x_amp01_re", int'(amp01_real), 32767);
        issue(4, 0, low);
        check("s_amp01_re", int'(amp01_real), 0);
        check("s_amp01_im", int'(amp01_imag), 32767);
        issue(2, 0, low);
        check("z_amp01_im", int'(amp01_imag), -32767);
        issue(6, 1, low);
        check("swap_amp10_im", int'(amp10_imag), -32767);
        check("swap_amp01_im", int'(amp01_imag), 0);
        check("swap_count", int'(gate_count), 4);

        // init beats a simultaneous gate request.
        init        = 1'b1;
        gate_valid  = 1'b1;
        gate_op     = 3'd1;
        gate_target = 1'b0;
        #1;
        check("init_ready", int'(gate_ready), 0);
        tick();
        init       = 1'b0;
        gate_valid = 1'b0;
        #1;
        check("init_amp00_re", int'(amp00_real), 32767);
        check("init_amp01_re", int'(amp01_real), 0);
        check("init_amp10_im", int'(amp10_imag), 0);
        check("init_count", int'(gate_count), 0);

        // Reset during the fourth Hadamard cycle discards the product scratch.
        issue(1, 1, low);
        gate_valid = 1'b1;
        gate_op    = 3'd3;
        tick();
        gate_valid = 1'b0;
        tick();
        tick();
        tick();
        reset = 1'b1;
        #1;
        check("midh_amp00_re", int'(amp00_real), 32767);
        check("midh_amp10_re", int'(amp10_real), 0);
        check("midh_count", int'(gate_count), 0);
        tick();
        reset = 1'b0;
        #1;
        check("midh_ready", int'(gate_ready), 1);
        repeat (10) tick();
        check("midh_no_wb_amp00", int'(amp00_real), 32767);
        check("midh_no_wb_amp10", int'(amp10_real), 0);

        // 256 NOPs wrap the counter and leave the state alone.
        do_reset();
        issue(1, 0, low);
        for (int i = 0; i < 256; i++) issue(($urandom_range(0, 1) != 0) ? 7 : 0, int'($urandom_range(0, 1)), low);
        check("nop_count_wrap", int'(gate_count), 1);
        check("nop_amp01_re", int'(amp01_real), 32767);
        check("nop_amp00_re", int'(amp00_real), 0);

        // Random traffic, including requests while busy, init and occasional resets.
        for (int i = 0; i < 1500; i++) begin
            gate_valid  = 1'($urandom_range(0, 1));
            gate_op     = ($urandom_range(0, 2) == 0) ? 3'd3 : 3'($urandom_range(0, 7));
            gate_target = 1'($urandom_range(0, 1));
            init        = ($urandom_range(0, 31) == 0);
            reset       = ($urandom_range(0, 299) == 0);
            tick();
        end
        reset      = 1'b0;
        init       = 1'b0;
        gate_valid = 1'b0;
        repeat (20) tick();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
